// File: rtl/ring_osc_pkg.sv
// Shared types, defaults and gate-length helper for the ring oscillator frequency counter.
package ring_osc_pkg;

   localparam int unsigned COUNT_W_DEF       = 16;
   localparam int unsigned GATE_MIN_LOG2_DEF = 8;
   localparam int unsigned SYNC_STAGES_DEF   = 2;
   localparam int unsigned GATE_SEL_W        = 3;
   localparam int unsigned BYTE_W            = 8;
   localparam int unsigned RESULT_BUS_W      = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_e;

   // Gate window length in clk cycles: 2^(min_log2 + sel).
   function automatic int unsigned gate_len(input logic [GATE_SEL_W-1:0] sel,
                                            input int unsigned           min_log2);
      return 32'd1 << (min_log2 + 32'(sel));
   endfunction

endpackage

// File: rtl/ring_osc_freq_counter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // One-cycle pulse on each synchronized 0->1 transition.
   assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Counts ring oscillator rising edges over a programmable gate window of clk cycles
// and presents the latched count one byte at a time.
module ring_osc_freq_counter
   import ring_osc_pkg::*;
#(
   parameter int unsigned COUNT_W       = COUNT_W_DEF,
   parameter int unsigned GATE_MIN_LOG2 = GATE_MIN_LOG2_DEF,
   parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  osc_in,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [GATE_SEL_W-1:0] gate_sel,
   input  logic                  byte_sel,
   output logic [BYTE_W-1:0]     result_byte,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int unsigned GATE_W = GATE_MIN_LOG2 + 7;
   localparam logic [0:0]  ST_IDLE = 1'(IDLE);
   localparam logic [0:0]  ST_GATE = 1'(GATE);

   logic [0:0]         state_q, state_d;
   logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic               ovf_q, ovf_d;
   logic [COUNT_W-1:0] result_q, result_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               rise;
   logic               cnt_sat;
   logic [COUNT_W-1:0] cnt_next;
   logic               ovf_next;
   logic [GATE_W-1:0]  gate_load;
   logic [RESULT_BUS_W-1:0] result_ext;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (osc_in),
      .rise_c   (rise)
   );

   // Saturating edge count and sticky overflow including this cycle's rise.
   assign cnt_sat   = &edge_cnt_q;
   assign cnt_next  = (rise && !cnt_sat) ? edge_cnt_q + COUNT_W'(1) : edge_cnt_q;
   assign ovf_next  = ovf_q | (rise & cnt_sat);
   assign gate_load = GATE_W'(gate_len(gate_sel, GATE_MIN_LOG2) - 32'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ovf_d      = ovf_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && ena) begin
               state_d    = ST_GATE;
               gate_cnt_d = gate_load;
               edge_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end
         ST_GATE: begin
            if (gate_cnt_q == '0) begin
               result_d   = cnt_next;
               overflow_d = ovf_next;
               done_d     = 1'b1;
               // Back-to-back reload keeps the next gate free of dead cycles.
               if (continuous && ena) begin
                  gate_cnt_d = gate_load;
                  edge_cnt_d = '0;
                  ovf_d      = 1'b0;
               end else begin
                  state_d    = ST_IDLE;
                  edge_cnt_d = cnt_next;
                  ovf_d      = ovf_next;
               end
            end else begin
               gate_cnt_d = gate_cnt_q - GATE_W'(1);
               edge_cnt_d = cnt_next;
               ovf_d      = ovf_next;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_GATE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // Result is zero-extended to the 16-bit bus view before byte selection.
   assign result_ext  = RESULT_BUS_W'(result_q);
   assign result_byte = byte_sel ? result_ext[15:8] : result_ext[7:0];

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed self-checking bench for ring_osc_freq_counter (16-bit and 8-bit count builds).
module tb_ring_osc_freq_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       osc_in;
   logic       start;
   logic       start8;
   logic       continuous;
   logic [2:0] gate_sel;
   logic       byte_sel;
   logic [7:0] result_byte, result_byte8;
   logic       busy, busy8, done, done8, overflow, overflow8;

   int total = 0;
   int bad   = 0;
   int osc_per = 0;
   logic osc_hold = 1'b0;

   ring_osc_freq_counter dut (
      .clk (clk), .rst_n (rst_n), .ena (ena), .osc_in (osc_in), .start (start),
      .continuous (continuous), .gate_sel (gate_sel), .byte_sel (byte_sel),
      .result_byte (result_byte), .busy (busy), .done (done), .overflow (overflow)
   );

   ring_osc_freq_counter #(.COUNT_W (8)) dut8 (
      .clk (clk), .rst_n (rst_n), .ena (ena), .osc_in (osc_in), .start (start8),
      .continuous (continuous), .gate_sel (gate_sel), .byte_sel (byte_sel),
      .result_byte (result_byte8), .busy (busy8), .done (done8), .overflow (overflow8)
   );

   always #5 clk = ~clk;

   // Oscillator model: square wave of osc_per clk cycles, changing on falling clk edges.
   initial begin : osc_gen
      int ph;
      ph = 0;
      osc_in = 1'b0;
      forever begin
         @(negedge clk);
         if (osc_per == 0) begin
            osc_in = osc_hold;
         end else begin
            ph = (ph + 1) % osc_per;
            osc_in = (ph < osc_per / 2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pair(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp_a, input logic [15:0] exp_b);
      total++;
      assert ((obs === exp_a) || (obs === exp_b)) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h or 0x%0h", tag, obs, exp_a, exp_b);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done8(input int bound, output int n);
      n = 0;
      while (!done8 && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic read16(output logic [15:0] v);
      byte_sel = 1'b0;
      #1;
      v[7:0] = result_byte;
      byte_sel = 1'b1;
      #1;
      v[15:8] = result_byte;
      byte_sel = 1'b0;
   endtask

   initial begin
      int n, n2, bc, dc, drops;
      logic [15:0] v;

      rst_n = 1'b0; ena = 1'b0; start = 1'b0; start8 = 1'b0;
      continuous = 1'b0; gate_sel = 3'd0; byte_sel = 1'b0;
      #1;
      // Reset state
      check("rst_result_byte", 32'(result_byte), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Start with ena low is ignored
      pulse_start();
      tick();
      check("start_no_ena_busy", 32'(busy), 32'h0);

      // Single gate, period 4, N=256
      ena = 1'b1;
      osc_per = 4;
      tick(); tick(); tick(); tick();
      pulse_start();
      bc = 0; dc = 0;
      for (int i = 0; i < 400; i++) begin
         if (busy) bc++;
         if (done) dc++;
         tick();
      end
      check("single_busy_cycles", 32'(bc), 32'd256);
      check("single_done_pulses", 32'(dc), 32'd1);
      check("single_lo_byte", 32'(result_byte), 32'h40);
      byte_sel = 1'b1;
      #1;
      check("single_hi_byte", 32'(result_byte), 32'h00);
      byte_sel = 1'b0;
      check("single_overflow", 32'(overflow), 32'h0);

      // Start mid-gate is ignored; done at original boundary
      pulse_start();
      for (int i = 0; i < 50; i++) tick();
      pulse_start();
      for (int i = 0; i < 49; i++) tick();
      wait_done(400, n);
      check("midstart_done_at", 32'(n), 32'd156);
      check("midstart_result", 32'(result_byte), 32'h40);
      tick();
      check("midstart_idle", 32'(busy), 32'h0);

      // Continuous, period 6, N=2048
      osc_per = 6;
      gate_sel = 3'd3;
      continuous = 1'b1;
      tick(); tick();
      pulse_start();
      wait_done(3000, n);
      check("cont_first_done_at", 32'(n), 32'd2048);
      check("cont_busy_at_done", 32'(busy), 32'h1);
      read16(v);
      check_pair("cont_first_value", v, 16'h155, 16'h156);
      n2 = 0; drops = 0;
      do begin
         tick();
         n2++;
         if (!busy) drops++;
      end while (!done && n2 < 3000);
      check("cont_second_done_gap", 32'(n2), 32'd2048);
      check("cont_busy_drops", 32'(drops), 32'd0);
      read16(v);
      check_pair("cont_second_value", v, 16'h155, 16'h156);

      // Clear continuous mid-gate: current gate completes, then idle
      for (int i = 0; i < 10; i++) tick();
      continuous = 1'b0;
      wait_done(3000, n);
      check("stop_done_at", 32'(n), 32'd2038);
      check("stop_busy_at_done", 32'(busy), 32'h0);
      read16(v);
      check_pair("stop_value", v, 16'h155, 16'h156);
      tick();
      check("stop_done_clear", 32'(done), 32'h0);
      check("stop_busy_idle", 32'(busy), 32'h0);

      // 8-bit build saturation, period 2, N=1024
      osc_per = 2;
      gate_sel = 3'd2;
      tick(); tick();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait_done8(2000, n);
      check("sat_done_at", 32'(n), 32'd1024);
      check("sat_lo_byte", 32'(result_byte8), 32'hFF);
      check("sat_overflow", 32'(overflow8), 32'h1);
      byte_sel = 1'b1;
      #1;
      check("sat_hi_byte_pad", 32'(result_byte8), 32'h00);
      byte_sel = 1'b0;

      // Following gate with oscillator held low
      osc_per = 0;
      osc_hold = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait_done8(2000, n);
      check("quiet_done_at", 32'(n), 32'd1024);
      check("quiet_result", 32'(result_byte8), 32'h00);
      check("quiet_overflow", 32'(overflow8), 32'h0);

      // Reset mid-gate
      osc_per = 4;
      gate_sel = 3'd0;
      tick(); tick();
      pulse_start();
      for (int i = 0; i < 50; i++) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_result", 32'(result_byte), 32'h00);
      check("midrst_overflow", 32'(overflow), 32'h0);
      tick();
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 400; i++) begin
         if (done) dc++;
         tick();
      end
      check("midrst_no_done", 32'(dc), 32'd0);
      check("midrst_idle", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
